slave_out_port: RTL and testbench

//  Serial transmit side of the slave port: sends read data to the master's input port over the 1-bit rx/tx line.

---
 rtl/slave_out_port_pkg.sv | 13 +
 rtl/slave_out_port_piso.sv | 50 +++++
 rtl/slave_out_port.sv | 130 +++++++++++++
 tb/tb_slave_out_port.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_out_port_pkg.sv
// Shared definitions for the slave serial transmit port: FSM state encoding and default widths.
package slave_out_port_pkg;

   localparam int DefDataLen  = 8;
   localparam int DefBurstLen = 12;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StValid = 2'b01,
      StSend  = 2'b10
   } state_e;

endpackage

// File: rtl/slave_out_port_piso.sv
// Parallel-in serial-out shifter: LSB-first, serial bit is the register LSB so the output is registered.
module SlaveOutPortPiso
   import slave_out_port_pkg::*;
#(
   parameter int DATA_LEN = DefDataLen,
   localparam int CntW    = $clog2(DATA_LEN)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic                shift_i,
   input  logic                clear_i,
   input  logic [DATA_LEN-1:0] data_i,
   output logic                serial_o,
   output logic [CntW-1:0]     bitCnt_o
);

   logic [DATA_LEN-1:0] shiftReg_q, shiftReg_d;
   logic [CntW-1:0]     bitCnt_q, bitCnt_d;

   // Clear wins so the line returns to 0 when a burst ends.
   always_comb begin
      shiftReg_d = shiftReg_q;
      bitCnt_d   = bitCnt_q;
      if (clear_i) begin
         shiftReg_d = '0;
         bitCnt_d   = '0;
      end else if (load_i) begin
         shiftReg_d = data_i;
         bitCnt_d   = '0;
      end else if (shift_i) begin
         shiftReg_d = shiftReg_q >> 1;
         bitCnt_d   = bitCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shiftReg_q <= '0;
         bitCnt_q   <= '0;
      end else begin
         shiftReg_q <= shiftReg_d;
         bitCnt_q   <= bitCnt_d;
      end
   end

   assign serial_o = shiftReg_q[0];
   assign bitCnt_o = bitCnt_q;

endmodule

// File: rtl/slave_out_port.sv
// Serial transmit side of the slave port: valid/ready handshake per word, then DATA_LEN bits LSB first.
module slave_out_port
   import slave_out_port_pkg::*;
#(
   parameter int DATA_LEN  = DefDataLen,
   parameter int BURST_LEN = DefBurstLen
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [BURST_LEN-1:0] burst_num,
   input  logic [DATA_LEN-1:0]  data_in,
   output logic                 word_taken,
   output logic                 busy,
   output logic                 tx_done,
   output logic                 tx_data,
   output logic                 slave_valid,
   input  logic                 master_ready
);

   localparam int              CntW    = $clog2(DATA_LEN);
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_LEN - 1);

   state_e               state_q, state_d;
   logic [BURST_LEN-1:0] burstLat_q, burstLat_d;
   logic [BURST_LEN-1:0] wordCnt_q, wordCnt_d;
   logic                 slaveValid_q, slaveValid_d;
   logic                 busy_q, busy_d;
   logic                 wordTaken_q, wordTaken_d;
   logic                 txDone_q, txDone_d;
   logic                 pisoLoad, pisoShift, pisoClear;
   logic [CntW-1:0]      bitCnt;
   logic                 serialBit;

   SlaveOutPortPiso #(.DATA_LEN(DATA_LEN)) uPiso (
      .clk      (clk),
      .reset    (reset),
      .load_i   (pisoLoad),
      .shift_i  (pisoShift),
      .clear_i  (pisoClear),
      .data_i   (data_in),
      .serial_o (serialBit),
      .bitCnt_o (bitCnt)
   );

   // The handshake edge itself carries bit 0, so it already shifts bit 1 onto the line.
   always_comb begin
      state_d      = state_q;
      burstLat_d   = burstLat_q;
      wordCnt_d    = wordCnt_q;
      slaveValid_d = slaveValid_q;
      busy_d       = busy_q;
      wordTaken_d  = 1'b0;
      txDone_d     = 1'b0;
      pisoLoad     = 1'b0;
      pisoShift    = 1'b0;
      pisoClear    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               pisoLoad     = 1'b1;
               slaveValid_d = 1'b1;
               burstLat_d   = burst_num;
               wordCnt_d    = '0;
               busy_d       = 1'b1;
               state_d      = StValid;
            end
         end
         StValid: begin
            if (master_ready) begin
               pisoShift    = 1'b1;
               slaveValid_d = 1'b0;
               wordTaken_d  = 1'b1;
               state_d      = StSend;
            end
         end
         StSend: begin
            if (bitCnt != LastBit) begin
               pisoShift = 1'b1;
            end else if (wordCnt_q == burstLat_q) begin
               pisoClear    = 1'b1;
               slaveValid_d = 1'b0;
               busy_d       = 1'b0;
               txDone_d     = 1'b1;
               state_d      = StIdle;
            end else begin
               pisoLoad     = 1'b1;
               slaveValid_d = 1'b1;
               wordCnt_d    = wordCnt_q + 1'b1;
               state_d      = StValid;
            end
         end
         default: begin
            pisoClear    = 1'b1;
            slaveValid_d = 1'b0;
            busy_d       = 1'b0;
            wordCnt_d    = '0;
            burstLat_d   = '0;
            state_d      = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         burstLat_q   <= '0;
         wordCnt_q    <= '0;
         slaveValid_q <= 1'b0;
         busy_q       <= 1'b0;
         wordTaken_q  <= 1'b0;
         txDone_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         burstLat_q   <= burstLat_d;
         wordCnt_q    <= wordCnt_d;
         slaveValid_q <= slaveValid_d;
         busy_q       <= busy_d;
         wordTaken_q  <= wordTaken_d;
         txDone_q     <= txDone_d;
      end
   end

   assign tx_data     = serialBit;
   assign slave_valid = slaveValid_q;
   assign busy        = busy_q;
   assign word_taken  = wordTaken_q;
   assign tx_done     = txDone_q;

endmodule

// File: tb/tb_slave_out_port.sv
// Self-checking bench for slave_out_port: a master model reassembles serial words and scores them.
module tb_slave_out_port;

   typedef struct {
      logic [11:0] burstNum;
      logic [31:0] words;
      int          stall;
      int          expWords;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [11:0] burst_num;
   logic [7:0]  data_in = 8'h00;
   logic        word_taken, busy, tx_done, tx_data, slave_valid;
   logic        master_ready;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  upQ[$];
   logic [7:0]  expQ[$];
   int          takenCnt = 0, doneCnt = 0, rxCnt = 0;
   int          baseTaken, baseDone, baseRx;
   bit          rxActive = 1'b0;
   int          bitIdx = 0;
   logic [7:0]  rxWord;
   vec_t        vecs[4];

   always #5 clk = ~clk;

   slave_out_port #(.DATA_LEN(8), .BURST_LEN(12)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .burst_num    (burst_num),
      .data_in      (data_in),
      .word_taken   (word_taken),
      .busy         (busy),
      .tx_done      (tx_done),
      .tx_data      (tx_data),
      .slave_valid  (slave_valid),
      .master_ready (master_ready)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkVec(input logic [11:0] b, input logic [31:0] w, input int s, input int e);
      vec_t v;
      v.burstNum = b;
      v.words    = w;
      v.stall    = s;
      v.expWords = e;
      return v;
   endfunction

   // Upstream word source: advances data_in after each word_taken pulse.
   always @(posedge clk) begin
      #1;
      if (word_taken && upQ.size() > 0) void'(upQ.pop_front());
      data_in = (upQ.size() > 0) ? upQ[0] : 8'h00;
   end

   // Master model: bit 0 is taken on the handshake edge, bit k on the k-th edge after it.
   always @(negedge clk) begin
      if (!reset) begin
         rxActive = 1'b0;
         bitIdx   = 0;
      end else begin
         if (word_taken) takenCnt++;
         if (tx_done) doneCnt++;
         if (rxActive) begin
            rxWord[bitIdx] = tx_data;
            bitIdx++;
            if (bitIdx == 8) begin
               rxActive = 1'b0;
               rxCnt++;
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL rx word unexpected: got 0x%0h, expected none", rxWord);
               end else begin
                  checkOutput("rx word", {24'h0, rxWord}, {24'h0, expQ.pop_front()});
               end
            end
         end else if (slave_valid && master_ready) begin
            rxWord[0] = tx_data;
            bitIdx    = 1;
            rxActive  = 1'b1;
         end
      end
   end

   task automatic waitDone(input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx_done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #2;
      end
      checkOutput("tx_done seen", {31'h0, got}, 32'h1);
      if (got) checkOutput("busy low on tx_done", {31'h0, busy}, 32'h0);
   endtask

   task automatic pushWords(input vec_t v);
      for (int w = 0; w < v.expWords; w++) begin
         upQ.push_back(v.words[8*w +: 8]);
         expQ.push_back(v.words[8*w +: 8]);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input bit doPush);
      for (int i = 0; i < 100 && busy; i++) begin
         @(posedge clk); #2;
      end
      baseTaken = takenCnt;
      baseDone  = doneCnt;
      baseRx    = rxCnt;
      if (doPush) pushWords(v);
      master_ready = (v.stall == 0);
      @(posedge clk); #2;
      burst_num = v.burstNum;
      start     = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      checkOutput("busy after start", {31'h0, busy}, 32'h1);
      checkOutput("valid after start", {31'h0, slave_valid}, 32'h1);
      checkOutput("bit0 after start", {31'h0, tx_data}, {31'h0, v.words[0]});
      for (int s = 0; s < v.stall; s++) begin
         @(posedge clk); #2;
         checkOutput("stall valid held", {31'h0, slave_valid}, 32'h1);
         checkOutput("stall bit0 held", {31'h0, tx_data}, {31'h0, v.words[0]});
         checkOutput("stall no take", {31'h0, word_taken}, 32'h0);
      end
      master_ready = 1'b1;
   endtask

   task automatic finishBurst(input int nWords, input int nDone);
      waitDone(nWords * 12 + 20);
      @(posedge clk); #2;
      checkOutput("tx_done one cycle", {31'h0, tx_done}, 32'h0);
      checkOutput("idle tx_data", {31'h0, tx_data}, 32'h0);
      checkOutput("idle valid", {31'h0, slave_valid}, 32'h0);
      checkOutput("word_taken count", takenCnt - baseTaken, nWords);
      checkOutput("rx word count", rxCnt - baseRx, nWords);
      checkOutput("tx_done count", doneCnt - baseDone, nDone);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t v;
      bit   got;
      vecs[0] = mkVec(12'd0, 32'h0000_00A5, 0, 1);
      vecs[1] = mkVec(12'd2, 32'h00FF_8001, 0, 3);
      vecs[2] = mkVec(12'd1, 32'h0000_C33C, 5, 2);
      vecs[3] = mkVec(12'd3, 32'h96FF_005A, 2, 4);

      reset = 1'b0; start = 1'b0; burst_num = '0; master_ready = 1'b0;
      #3;
      checkOutput("reset outputs", {27'h0, word_taken, busy, tx_done, tx_data, slave_valid}, 32'h0);
      @(posedge clk); @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      checkOutput("idle busy", {31'h0, busy}, 32'h0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i], 1'b1);
         finishBurst(vecs[i].expWords, 1);
      end

      // Start pulses while busy must not restart or extend the burst.
      v = mkVec(12'd1, 32'h0000_3412, 0, 2);
      applyStimulus(v, 1'b1);
      for (int i = 0; i < 20 && !word_taken; i++) begin
         @(posedge clk); #2;
      end
      @(posedge clk); #2;
      burst_num = 12'hFFF;
      start     = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      finishBurst(2, 1);
      checkOutput("busy after ignored start", {31'h0, busy}, 32'h0);

      // Start coinciding with tx_done starts a fresh burst with the new length.
      v = mkVec(12'd0, 32'h0000_006E, 0, 1);
      pushWords(v);
      pushWords(mkVec(12'd1, 32'h0000_D721, 0, 2));
      applyStimulus(v, 1'b0);
      waitDone(40);
      burst_num = 12'd1;
      start     = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      checkOutput("back-to-back busy", {31'h0, busy}, 32'h1);
      checkOutput("back-to-back valid", {31'h0, slave_valid}, 32'h1);
      checkOutput("back-to-back bit0", {31'h0, tx_data}, 32'h1);
      finishBurst(3, 2);

      // Asynchronous reset mid-burst aborts with no tx_done.
      v = mkVec(12'd1, 32'h0000_2211, 0, 2);
      applyStimulus(v, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (word_taken) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #2;
      end
      checkOutput("word_taken before reset", {31'h0, got}, 32'h1);
      repeat (3) @(posedge clk);
      #2;
      checkOutput("busy before reset", {31'h0, busy}, 32'h1);
      baseDone = doneCnt;
      reset = 1'b0;
      #1;
      checkOutput("async reset outputs", {27'h0, word_taken, busy, tx_done, tx_data, slave_valid}, 32'h0);
      upQ.delete();
      expQ.delete();
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("post-reset idle", {30'h0, busy, slave_valid}, 32'h0);
      checkOutput("no tx_done on abort", doneCnt - baseDone, 0);

      applyStimulus(mkVec(12'd0, 32'h0000_00C9, 0, 1), 1'b1);
      finishBurst(1, 1);
      checkOutput("scoreboard drained", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
